// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the three-requester memory port arbiter.
//   - requester index constants and requester count
//   - arbiter state encoding
//   - round-robin index helpers used by the picker and the top level
package mem_port_arbiter_pkg;

  localparam int NUM_REQ = 3;
  localparam int IDX_W   = 2;
  localparam int BURST_W = 8;  // holds MAX_BURST up to 255

  typedef logic [IDX_W-1:0] req_idx_t;

  localparam req_idx_t LOADER  = 2'd0;  // matrix-1/2 loader
  localparam req_idx_t COMPUTE = 2'd1;  // compute engine
  localparam req_idx_t READER  = 2'd2;  // result reader

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  // Next requester index in round-robin order, wrapping READER -> LOADER.
  function automatic req_idx_t rr_next(input req_idx_t idx);
    return (idx == READER) ? LOADER : req_idx_t'(idx + 2'd1);
  endfunction

  // Index of the set bit in a one-hot requester vector.
  function automatic req_idx_t onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    req_idx_t idx;
    case (oh)
      3'b010:  idx = COMPUTE;
      3'b100:  idx = READER;
      default: idx = LOADER;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick3.sv
// rr_pick3: combinational 3-way round-robin priority picker.
//   req_i   - request vector, one bit per requester
//   start_i - index examined first; the search wraps and ends at start_i-1
//   pick_o  - one-hot winner (zero when nothing is requested)
//   valid_o - a winner exists
module rr_pick3
  import mem_port_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  req_idx_t           start_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic               valid_o
);

  always_comb begin
    req_idx_t cand;
    logic     found;
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    pick_o = '0;
    found  = 1'b0;
    cand   = start_i;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_i[cand]) begin
        pick_o[cand] = 1'b1;
        found        = 1'b1;
      end
      cand = rr_next(cand);
    end
    valid_o = found;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between three requesters
// (loader, compute engine, result reader) with registered round-robin grants,
// optional locked bursts bounded by MAX_BURST, and per-requester read-valid.
//   clk, rst            - clock, asynchronous active-low reset
//   req/lock/wEN        - per-requester request, keep-ownership, write select
//   addr/wdata          - per-requester address / write data, slice i = requester i
//   gnt                 - registered one-hot-or-zero grant
//   rvalid/rdata        - read strobe for the requester whose read returns; shared data
//   memEN/memwEN/memaddr/memwdata - command to the memory, muxed from the owner
//   memrdata            - memory read data, one cycle after the read command
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    lock,
  input  logic [NUM_REQ-1:0]    wEN,
  input  logic [NUM_REQ*AW-1:0] addr,
  input  logic [NUM_REQ*DW-1:0] wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic [DW-1:0]         rdata,
  output logic                  memEN,
  output logic                  memwEN,
  output logic [AW-1:0]         memaddr,
  output logic [DW-1:0]         memwdata,
  input  logic [DW-1:0]         memrdata
);

  localparam logic [BURST_W-1:0] MAX_BURST_C = BURST_W'(MAX_BURST);

  arb_state_e           state_q, state_d;
  req_idx_t             owner_q, owner_d;
  req_idx_t             rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
  // Cleared by reset, set on the first edge afterwards: keeps the first grant
  // off the edge that immediately follows reset release.
  logic                 arb_en_q;

  logic                 owned;
  logic                 owner_req;
  logic                 hold;
  req_idx_t             pick_start;
  logic [NUM_REQ-1:0]   pick_vec;
  logic                 pick_valid;
  req_idx_t             pick_idx;

  assign owned     = (state_q == ST_OWNED);
  assign owner_req = owned && req[owner_q];
  assign hold      = owner_req && lock[owner_q] && (burst_q < MAX_BURST_C);

  // After an owner the search begins just past it, so the old owner is the
  // last candidate; from idle it begins at the round-robin pointer.
  assign pick_start = owned ? rr_next(owner_q) : rr_ptr_q;

  rr_pick3 u_pick (
    .req_i   (req),
    .start_i (pick_start),
    .pick_o  (pick_vec),
    .valid_o (pick_valid)
  );

  assign pick_idx = onehot_to_idx(pick_vec);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    burst_d  = burst_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    if (arb_en_q) begin
      if (hold) begin
        burst_d = burst_q + BURST_W'(1);
      end else if (pick_valid) begin
        // A re-grant of the same requester also restarts the burst count.
        state_d  = ST_OWNED;
        owner_d  = pick_idx;
        burst_d  = BURST_W'(1);
        rr_ptr_d = rr_next(pick_idx);
        gnt_d    = pick_vec;
      end else begin
        state_d = ST_IDLE;
        owner_d = LOADER;
        burst_d = '0;
        gnt_d   = '0;
      end
    end
  end

  // Memory command follows the registered owner but only while it still
  // requests; a dropped request issues nothing in that cycle.
  always_comb begin
    memEN    = 1'b0;
    memwEN   = 1'b0;
    memaddr  = '0;
    memwdata = '0;
    if (owner_req) begin
      memEN    = 1'b1;
      memwEN   = wEN[owner_q];
      memaddr  = addr[int'(owner_q)*AW +: AW];
      memwdata = wdata[int'(owner_q)*DW +: DW];
    end
  end

  // The read strobe is tagged with the issuing owner, so it lands correctly
  // even when ownership moves on the same edge.
  assign rvalid_d = (owner_req && !wEN[owner_q]) ? gnt_q : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= LOADER;
      rr_ptr_q <= LOADER;
      burst_q  <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      arb_en_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      arb_en_q <= 1'b1;
    end
  end

  assign gnt    = gnt_q;
  assign rvalid = rvalid_q;
  // Memory data arrives in the strobe cycle; forced to zero otherwise.
  assign rdata  = (|rvalid_q) ? memrdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, default 8, address width of the shared memory port.
REQ-002 Parameter DW, default 8, data width of the shared memory port.
REQ-003 Parameter MAX_BURST, default 16, maximum consecutive locked grant cycles before forced release (range 1..255).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-006 req  input  3  per-requester access request; bit 0 = matrix-1/2 loader, bit 1 = compute engine, bit 2 = result reader.
REQ-007 lock  input  3  per-requester request to keep ownership across consecutive cycles.
REQ-008 wEN  input  3  per-requester write (1) / read (0) select.
REQ-009 addr  input  3*AW  per-requester address, requester i at bits [i*AW +: AW].
REQ-010 wdata  input  3*DW  per-requester write data, same packing as addr.
REQ-011 gnt  output  3  one-hot-or-zero registered grant.
REQ-012 rvalid  output  3  per-requester read-data-valid strobe.
REQ-013 rdata  output  DW  shared read data, meaningful only when some rvalid bit is 1.
REQ-014 memEN, memwEN  output  1 each  shared memory enable and write enable.
REQ-015 memaddr  output  AW;  memwdata  output  DW;  memrdata  input  DW (memory read latency 1 cycle).

Function
REQ-016 States: IDLE (gnt = 0) and OWNED (exactly one gnt bit = 1); owner index and burst counter are registered.
REQ-017 Arbitration is evaluated every cycle from current req and state; the resulting gnt is registered, so a request raised in cycle t is granted no earlier than cycle t+1.
REQ-018 Owner g keeps the grant while req[g] = 1, lock[g] = 1 and burst count < MAX_BURST.
REQ-019 Otherwise the next owner is the first requester with req = 1 searching round-robin from (g+1) mod 3, the previous owner being the last candidate; from IDLE the search starts at the round-robin pointer.
REQ-020 Round-robin pointer updates to (new owner + 1) mod 3 on every new grant; reset value 0.
REQ-021 If no req bit is 1, next state is IDLE and gnt = 0.
REQ-022 Burst counter resets to 1 on each new grant (including re-grant of the same requester) and increments each cycle the grant is held; at MAX_BURST the grant is forcibly re-arbitrated even if lock is 1.
REQ-023 When gnt[i] = 1 and req[i] = 1: memEN = 1, memwEN = wEN[i], memaddr and memwdata are slice i (combinational mux from registered owner).
REQ-024 When gnt[i] = 1 but req[i] = 0, or in IDLE: memEN = 0, memwEN = 0, memaddr and memwdata = 0.
REQ-025 rvalid[i] = 1 exactly one cycle after a cycle with gnt[i] = req[i] = 1 and wEN[i] = 0; rdata = memrdata in that cycle; rvalid is registered and at most one bit is 1.
REQ-026 A read issued in the final cycle of a grant still produces its rvalid in the next cycle, even if ownership has changed.
REQ-027 Simultaneous requests from all three in IDLE after reset: requester 0 is granted first.
REQ-028 Dropping req mid-burst releases ownership at the next edge; no memory command is issued in the dropping cycle.

Reset
REQ-029 While rst = 0: state IDLE, gnt = 0, rvalid = 0, pointer = 0, burst counter = 0, memEN = memwEN = 0, memaddr = memwdata = 0, rdata = 0.
REQ-030 Reset asserted mid-burst aborts immediately; a pending read produces no rvalid.
REQ-031 First grant after reset release occurs no earlier than the second rising edge after rst goes high.

Structure
REQ-032 Requester index constants (LOADER = 0, COMPUTE = 1, READER = 2), requester count 3 and state encoding belong in the shared project package.
REQ-033 One sub-module is natural: rr_pick3, a combinational 3-way round-robin priority picker (inputs request vector and start index; outputs one-hot pick and valid).

Verification
REQ-034 Reset then req = 3'b111, lock = 0 held -> gnt sequence 001, 010, 100, 001 on consecutive cycles.
REQ-035 req[1] = lock[1] = 1 held, MAX_BURST = 4, req[0] = 1 -> gnt = 010 for 4 cycles, then 001 for one cycle, then 010 again.
REQ-036 Loader granted, wEN[0] = 1, addr = 8'h05, wdata = 8'hA3 -> memEN = 1, memwEN = 1, memaddr = 8'h05, memwdata = 8'hA3 in the same cycle; rvalid stays 0.
REQ-037 Reader granted, read addr 8'h08, memory returns 8'h3C -> rvalid = 3'b100 and rdata = 8'h3C one cycle later, including when that read is the last granted cycle.
REQ-038 rst driven low mid-burst with read in flight -> gnt, rvalid, memEN = 0 immediately; after release req = 3'b110 -> gnt = 010 first.
REQ-039 Random req/lock/wEN for 10000 cycles -> gnt always one-hot-or-zero, no requester waits more than 2*MAX_BURST + 2 cycles while req held.
